data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Parametrised successor to the byte-lane test RAM.
- Adds four things: RISC-V sized load/store decoding (funct3 encoding), sign/zero extension, misalignment and illegal-size error reporting, and a valid/ready request/response handshake with configurable read latency.
- Sits between the core's load/store unit and on-chip data storage. One transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 12, byte-address width. Storage is 2^(ADDR_WIDTH-2) words of 32 bits, organised as 4 byte lanes. Legal range 3..20.
- LATENCY, 1, cycles from request acceptance to rsp_valid. Legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned (B uses [7:0], H uses [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_error  out  1  misaligned or illegal request.

Behaviour:
- Reset (async assert, sync-safe release):
  - State returns to IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, latency counter=0.
  - Storage contents are not reset.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid&req_ready, capture the request and go to WAIT with counter=LATENCY-1. If LATENCY=1, go directly to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle; go to RESP when counter reaches 0.
  - RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_error are held stable until rsp_valid&rsp_ready; then go to IDLE.
- Timing:
  - A request accepted at edge k gives rsp_valid=1 in the cycle after edge k+LATENCY-1, i.e. LATENCY cycles after acceptance.
  - There is no same-cycle response-to-request overlap: req_ready rises the cycle after the response handshake.
  - Peak throughput is one transaction per LATENCY+1 cycles.
- Error check, performed at acceptance:
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal size: 011, 110 or 111, or a store with size 100/101.
  - On error: no storage write, rsp_error=1, rsp_rdata=0, same latency as a good response.
- Stores:
  - Storage is written at the acceptance edge.
  - Word index is addr[ADDR_WIDTH-1:2].
  - SB: lane addr[1:0] gets wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} get wdata[7:0] and wdata[15:8] respectively.
  - SW: all lanes get the full word, little-endian.
  - Other lanes are unchanged. Response: rsp_rdata=0, rsp_error=0.
- Loads:
  - The word is read at the acceptance edge. Lane select and extension are applied before storing into the response register.
  - LB/LBU: byte at lane addr[1:0], sign- or zero-extended respectively.
  - LH/LHU: halfword at lanes {addr[1],*}, sign- or zero-extended respectively.
  - LW: whole word.
- Ordering: a load accepted after a store's acceptance edge returns the stored data.
- Reset mid-operation (WAIT or RESP):
  - The response is discarded and the FSM returns to IDLE.
  - A store already accepted remains committed in storage.
- Inputs while busy: req_* are ignored when req_ready=0. The requester must hold the request until it is accepted.

Test Plan:
- Reset, then SW addr 0x010 data 0xDEADBEEF, then LW 0x010. Required: store response rdata=0, err=0; load rsp_valid exactly LATENCY cycles after acceptance, rdata=0xDEADBEEF.
- Byte lanes: after the word above, SB 0x013 data 0x00000012. Required responses:
  - LW 0x010 = 0x12ADBEEF.
  - LB 0x011 = 0xFFFFFFBE.
  - LBU 0x011 = 0x000000BE.
  - LH 0x012 = 0x000012AD.
  - LHU 0x010 = 0x0000BEEF.
- Errors:
  - LH 0x011 gives err=1, rdata=0.
  - SW 0x012 data 0x11111111 gives err=1, and a following LW 0x010 still returns 0x12ADBEEF.
  - Size 011 gives err=1.
  - A store with size 100 gives err=1.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid. Required: rdata/err stable, req_ready=0 throughout.
  - Then raise rsp_ready. Required: next-cycle req_ready=1, rsp_valid=0.
- Latency sweep: run LATENCY=1 and LATENCY=4 builds. Required: acceptance-to-rsp_valid distance is 1 and 4 cycles respectively; req_ready is low for the whole interval.
- Reset mid-WAIT (LATENCY=4) after an accepted SW 0x020 data 0xCAFEF00D. Required: immediately rsp_valid=0, req_ready=1; after release, LW 0x020 = 0xCAFEF00D.

Source files
------------

// File: rtl/data_mem.sv
// Load/store data RAM with RISC-V sized accesses, sign/zero extension,
// error reporting and a valid/ready handshake with configurable read latency.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a request; accepted request is decoded and captured
// S_WAIT | latency down-counter running, response already computed
// S_RESP | response presented, held until rsp_ready
module data_mem #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_d;
  logic [2:0] cnt, cnt_d;

  logic [31:0] mem [WORDS];

  logic                  accept;
  logic                  size_illegal;
  logic                  misaligned;
  logic                  req_err;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           load_data;
  logic [3:0]            wr_be;
  logic [31:0]           wr_word;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_error_q;

  assign accept   = req_valid && (state == S_IDLE);
  assign word_idx = req_addr[ADDR_WIDTH-1:2];
  assign rd_word  = mem[word_idx];

  // Decode of funct3 size and alignment; stores have no unsigned variants.
  always_comb begin
    size_illegal = 1'b0;
    misaligned   = 1'b0;
    case (req_size)
      3'b000, 3'b100: size_illegal = req_write && req_size[2];
      3'b001, 3'b101: begin
        size_illegal = req_write && req_size[2];
        misaligned   = req_addr[0];
      end
      3'b010:  misaligned   = (req_addr[1:0] != 2'b00);
      default: size_illegal = 1'b1;
    endcase
  end

  assign req_err = size_illegal || misaligned;

  always_comb begin
    rd_byte   = 8'h00;
    rd_half   = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'h0;
    case (req_addr[1:0])
      2'b00: rd_byte = rd_word[7:0];
      2'b01: rd_byte = rd_word[15:8];
      2'b10: rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    case (req_size)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'h0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'h0, rd_half};
      3'b010:  load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    wr_be   = 4'b0000;
    wr_word = req_wdata;
    case (req_size[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << req_addr[1:0];
        wr_word = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{req_wdata[15:0]}};
      end
      default: wr_be = 4'b1111;
    endcase
  end

  // Storage is not reset; a store commits at its acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt - 3'd1;
        if (cnt == 3'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        rsp_rdata_q <= (req_write || req_err) ? 32'h0 : load_data;
        rsp_error_q <= req_err;
      end
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: LATENCY=1 and LATENCY=4 instances checked against a
// byte-array reference model with directed and randomized transactions.
module tb_data_mem;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [1:0]          req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_error;
  logic [1:0][2:0]     req_size;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][31:0]    req_wdata, rsp_rdata;

  int checks = 0;
  int errors = 0;
  int lat_of [2] = '{1, 4};
  logic [7:0] ref_mem [2][1<<AW];

  data_mem #(.ADDR_WIDTH(AW), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
  );

  data_mem #(.ADDR_WIDTH(AW), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: memory as plain bytes, result from width and signedness.
  function automatic void model(input int d, input logic w, input logic [2:0] sz,
                                input int a, input logic [31:0] wd,
                                output logic [31:0] er, output logic ee);
    int n;
    logic [31:0] v;
    bit illegal;
    bit mis;
    illegal = (sz == 3 || sz == 6 || sz == 7) || (w && (sz == 4 || sz == 5));
    mis     = ((sz == 1 || sz == 5) && (a % 2 != 0)) || (sz == 2 && (a % 4 != 0));
    n       = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
    ee      = illegal || mis;
    er      = 32'h0;
    if (ee) return;
    if (w) begin
      for (int i = 0; i < n; i++) ref_mem[d][a+i] = wd[8*i +: 8];
      return;
    end
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[d][a+i]) << (8*i));
    if (!sz[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    er = v;
  endfunction

  // Starts and ends #1 after a rising edge.
  task automatic txn(input int d, input logic w, input logic [2:0] sz, input int a,
                     input logic [31:0] wd, input int hold, input string tag);
    logic [31:0] er;
    logic        ee;
    int          n;
    model(d, w, sz, a, wd, er, ee);
    check({tag, "/ready_idle"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_size[d]  = sz;
    req_addr[d]  = AW'(a);
    req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 1;
    while (!rsp_valid[d] && n < 20) begin
      check({tag, "/ready_busy"}, 32'(req_ready[d]), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check({tag, "/latency"}, 32'(n), 32'(lat_of[d]));
    check({tag, "/rdata"}, rsp_rdata[d], er);
    check({tag, "/error"}, 32'(rsp_error[d]), 32'(ee));
    check({tag, "/ready_rsp"}, 32'(req_ready[d]), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 32'(rsp_valid[d]), 32'd1);
      check({tag, "/hold_rdata"}, rsp_rdata[d], er);
      check({tag, "/hold_error"}, 32'(rsp_error[d]), 32'(ee));
      check({tag, "/hold_ready"}, 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    check({tag, "/post_valid"}, 32'(rsp_valid[d]), 32'd0);
    check({tag, "/post_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    logic [31:0] er;
    logic        ee;
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_size  = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = '0;
    #2;
    for (int d = 0; d < 2; d++) begin
      check("reset/req_ready", 32'(req_ready[d]), 32'd1);
      check("reset/rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("reset/rsp_rdata", rsp_rdata[d], 32'd0);
      check("reset/rsp_error", 32'(rsp_error[d]), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      txn(d, 1, 3'b010, 'h010, 32'hDEADBEEF, 0, "sw_010");
      txn(d, 0, 3'b010, 'h010, 32'h0, 0, "lw_010");
      txn(d, 1, 3'b000, 'h013, 32'h00000012, 0, "sb_013");
      txn(d, 0, 3'b010, 'h010, 32'h0, 0, "lw_010_b");
      txn(d, 0, 3'b000, 'h011, 32'h0, 0, "lb_011");
      txn(d, 0, 3'b100, 'h011, 32'h0, 0, "lbu_011");
      txn(d, 0, 3'b001, 'h012, 32'h0, 0, "lh_012");
      txn(d, 0, 3'b101, 'h010, 32'h0, 0, "lhu_010");
      txn(d, 0, 3'b001, 'h011, 32'h0, 0, "lh_mis");
      txn(d, 1, 3'b010, 'h012, 32'h11111111, 0, "sw_mis");
      txn(d, 0, 3'b010, 'h010, 32'h0, 0, "lw_after_err");
      txn(d, 0, 3'b011, 'h010, 32'h0, 0, "size_011");
      txn(d, 1, 3'b100, 'h010, 32'h55, 0, "st_size_100");
    end

    txn(0, 0, 3'b010, 'h010, 32'h0, 5, "backpressure_l1");
    txn(1, 0, 3'b000, 'h013, 32'h0, 5, "backpressure_l4");

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) txn(d, 1, 3'b010, 'h100 + 4*i, $urandom, 0, "fill");
      for (int i = 0; i < 40; i++) begin
        txn(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            'h100 + $urandom_range(0, 63), $urandom, $urandom_range(0, 2), "rand");
      end
    end

    // Reset while the LATENCY=4 instance is counting down after a store.
    model(1, 1, 3'b010, 'h020, 32'hCAFEF00D, er, ee);
    check("rst_wait/ready_idle", 32'(req_ready[1]), 32'd1);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_size[1]  = 3'b010;
    req_addr[1]  = AW'('h020);
    req_wdata[1] = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    check("rst_wait/busy", 32'(req_ready[1]), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_wait/rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check("rst_wait/req_ready", 32'(req_ready[1]), 32'd1);
    check("rst_wait/rsp_error", 32'(rsp_error[1]), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_wait/idle_after", 32'(rsp_valid[1]), 32'd0);
    txn(1, 0, 3'b010, 'h020, 32'h0, 0, "lw_020_after_rst");
    txn(0, 0, 3'b010, 'h010, 32'h0, 0, "l1_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
